// File: rtl/dac_frame_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_frame_delay_line_if
// Description : Sample/frame/valid bundle between the AFE return path and the
//               DAC frame delay line, including hold/mute/latency controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_frame_delay_line_if #(
    parameter int DATA_W = 24,
    parameter int SEL_W  = 4
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_frame;
    logic              in_valid;
    logic              hold;
    logic              mute;
    logic [SEL_W-1:0]  delay_sel;
    logic [DATA_W-1:0] out_data;
    logic              out_frame;
    logic              out_valid;
    logic              settled;

    modport master (
        output in_data, in_frame, in_valid, hold, mute, delay_sel,
        input  out_data, out_frame, out_valid, settled
    );

    modport slave (
        input  in_data, in_frame, in_valid, hold, mute, delay_sel,
        output out_data, out_frame, out_valid, settled
    );
endinterface
`default_nettype wire

// File: rtl/dac_frame_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : dac_frame_delay_line
// Description : Programmable 1..MAX_DEPTH cycle delay for DAC return samples
//               with hold, mute and a settle window after latency changes.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_frame_delay_line #(
    parameter int DATA_W    = 24,
    parameter int MAX_DEPTH = 16,
    parameter int SEL_W     = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    dac_frame_delay_line_if.slave  bus
);

    localparam int WORD_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(MAX_DEPTH + 1);
    localparam logic [SEL_W-1:0] C_MAX_IDX = SEL_W'(MAX_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_load;
    logic [SEL_W-1:0]    r_dsel_q;
    logic [SEL_W-1:0]    w_sel_idx;
    logic [SEL_W-1:0]    w_cur_idx;
    logic                w_adv;
    logic                w_change;
    logic                w_run_nxt;
    logic [WORD_W-1:0]   w_in_word;
    logic [WORD_W-1:0]   w_tap;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_frame;
    logic                r_out_valid;
    logic                r_settled;

    function automatic logic [SEL_W-1:0] clamp_idx(input logic [SEL_W-1:0] sel);
        return (sel > C_MAX_IDX) ? C_MAX_IDX : sel;
    endfunction

    assign w_in_word  = {bus.in_data, bus.in_frame, bus.in_valid};
    assign w_adv      = ~bus.hold;
    assign w_change   = (bus.delay_sel != r_dsel_q);
    assign w_sel_idx  = clamp_idx(bus.delay_sel);
    assign w_cur_idx  = clamp_idx(r_dsel_q);
    assign w_cnt_load = CNT_W'(w_sel_idx) + CNT_W'(1);

    // The output register acts as the last stage: after an advance it holds
    // what stage[D-1] would hold, so only D-1 storage stages sit in front.
    generate
        if (MAX_DEPTH > 1) begin : g_chain
            logic [WORD_W-1:0] r_stage [MAX_DEPTH-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < MAX_DEPTH - 1; k++) begin
                        r_stage[k] <= '0;
                    end
                end else if (w_adv) begin
                    r_stage[0] <= w_in_word;
                    for (int k = 1; k < MAX_DEPTH - 1; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            always_comb begin
                w_tap = w_in_word;
                for (int k = 0; k < MAX_DEPTH - 1; k++) begin
                    if (w_cur_idx == SEL_W'(k + 1)) begin
                        w_tap = r_stage[k];
                    end
                end
            end
        end else begin : g_single
            assign w_tap = w_in_word;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_dsel_q  <= '0;
            r_settled <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dsel_q  <= bus.delay_sel;
            r_settled <= (w_state_nxt == ST_RUN);
        end
    end

    // A latency change wins over everything, including hold, and restarts
    // the settle window with the newly requested depth.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_change) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = w_cnt_load;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (w_adv) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_frame <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_data  <= (w_run_nxt && !bus.mute) ? w_tap[WORD_W-1:2] : '0;
            r_out_frame <= w_run_nxt & w_tap[1];
            r_out_valid <= w_run_nxt & w_tap[0];
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_frame = r_out_frame;
    assign bus.out_valid = r_out_valid;
    assign bus.settled   = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_frame_delay_line
// Description : Random and directed stimulus on MAX_DEPTH=16 and MAX_DEPTH=8
//               instances against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_frame_delay_line;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   ramp;

    dac_frame_delay_line_if #(.DATA_W(24), .SEL_W(4)) bus  ();
    dac_frame_delay_line_if #(.DATA_W(24), .SEL_W(4)) bus8 ();

    assign bus8.in_data   = bus.in_data;
    assign bus8.in_frame  = bus.in_frame;
    assign bus8.in_valid  = bus.in_valid;
    assign bus8.hold      = bus.hold;
    assign bus8.mute      = bus.mute;
    assign bus8.delay_sel = bus.delay_sel;

    dac_frame_delay_line #(.DATA_W(24), .MAX_DEPTH(16), .SEL_W(4)) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    dac_frame_delay_line #(.DATA_W(24), .MAX_DEPTH(8), .SEL_W(4)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every accepted word is appended to a history; the
    // output after an advance is the word accepted D advances ago (D=1 is
    // the word just accepted), gated by whether the settle window is over.
    logic [25:0] hist[$];
    int          dsel_q [2];
    bit          run    [2];
    int          rem    [2];
    logic [23:0] e_data [2];
    bit          e_fr   [2];
    bit          e_vl   [2];

    function automatic int eff_d(input int sel, input int maxd);
        return (sel + 1 > maxd) ? maxd : sel + 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int m = 0; m < 2; m++) begin
            dsel_q[m] = 0;
            run[m]    = 1'b1;
            rem[m]    = 0;
            e_data[m] = '0;
            e_fr[m]   = 1'b0;
            e_vl[m]   = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          adv;
        int          maxd;
        int          d;
        int          sel;
        logic [25:0] w;
        adv = !bus.hold;
        sel = int'(bus.delay_sel);
        if (adv) hist.push_back({bus.in_data, bus.in_frame, bus.in_valid});
        for (int m = 0; m < 2; m++) begin
            maxd = (m == 0) ? 16 : 8;
            if (sel != dsel_q[m]) begin
                dsel_q[m] = sel;
                rem[m]    = eff_d(sel, maxd);
                run[m]    = 1'b0;
            end else if (!run[m] && adv) begin
                rem[m]--;
                if (rem[m] == 0) run[m] = 1'b1;
            end
            if (adv) begin
                d = eff_d(dsel_q[m], maxd);
                w = (hist.size() >= d) ? hist[hist.size() - d] : 26'd0;
                e_data[m] = (run[m] && !bus.mute) ? w[25:2] : 24'd0;
                e_fr[m]   = run[m] & w[1];
                e_vl[m]   = run[m] & w[0];
            end
        end
    endtask

    task automatic check_all();
        check_val("d16.data",    32'(bus.out_data),   32'(e_data[0]));
        check_val("d16.frame",   32'(bus.out_frame),  32'(e_fr[0]));
        check_val("d16.valid",   32'(bus.out_valid),  32'(e_vl[0]));
        check_val("d16.settled", 32'(bus.settled),    32'(run[0]));
        check_val("d8.data",     32'(bus8.out_data),  32'(e_data[1]));
        check_val("d8.frame",    32'(bus8.out_frame), 32'(e_fr[1]));
        check_val("d8.valid",    32'(bus8.out_valid), 32'(e_vl[1]));
        check_val("d8.settled",  32'(bus8.settled),   32'(run[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic [23:0] d, input bit f, input bit v,
                         input bit h, input bit m, input logic [3:0] s);
        bus.in_data   = d;
        bus.in_frame  = f;
        bus.in_valid  = v;
        bus.hold      = h;
        bus.mute      = m;
        bus.delay_sel = s;
    endtask

    task automatic drive_random(input int change_odds);
        logic [3:0] s;
        s = bus.delay_sel;
        if ($urandom_range(0, change_odds - 1) == 0) s = 4'($urandom_range(0, 15));
        drive(24'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, s);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ramp    = 100;
        reset_n = 1'b0;
        drive(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Legacy single-register latency
        for (int i = 1; i <= 5; i++) begin
            drive(24'(i), 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end

        // Latency 4 on a ramp
        for (int i = 0; i < 20; i++) begin
            drive(24'(ramp), 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
            ramp++;
            tick();
        end

        // Maximum request: 16 on the deep instance, clamped to 8 on the other
        for (int i = 0; i < 40; i++) begin
            drive(24'(ramp), i == 20, 1'b1, 1'b0, 1'b0, 4'hF);
            ramp++;
            tick();
        end

        // Back to 4 with hold inside the settle window, hold in RUN, then mute
        for (int i = 0; i < 30; i++) begin
            drive(24'(ramp), i == 12, 1'b1, (i >= 1 && i <= 3) || (i >= 15 && i <= 17),
                  i == 22 || i == 23, 4'd3);
            ramp++;
            tick();
        end

        // Latency change coinciding with hold
        drive(24'(ramp), 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(24'(ramp), 1'b0, 1'b1, i < 2, 1'b0, 4'd5);
            ramp++;
            tick();
        end

        for (int i = 0; i < 600; i++) begin
            drive_random(20);
            tick();
        end

        // Asynchronous reset in the middle of an 8-cycle settle
        drive(24'(ramp), 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        bus.delay_sel = 4'd0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(24'(ramp), i == 2, 1'b1, 1'b0, 1'b0, 4'd0);
            ramp++;
            tick();
        end

        for (int i = 0; i < 300; i++) begin
            drive_random(8);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_frame_delay_line.md
Name: dac_frame_delay_line

Overview:
Parametrised successor to the single-stage DAC return register. It carries parallel sample words plus a frame marker and a valid qualifier back to the DAC path, with a runtime-programmable latency of 1..MAX_DEPTH cycles. It also provides hold (clock-enable), mute and a settle state machine, so that a latency change never emits stale or misaligned samples. It sits between the AFE receive datapath and the DAC transmit formatter.

Parameters:
DATA_W, 24, width of sample word (frame bits included if packed by caller)
MAX_DEPTH, 16, number of pipeline stages, i.e. the maximum latency in cycles (>=1)
SEL_W, 4, width of delay_sel; must satisfy 2**SEL_W >= MAX_DEPTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_data  in  DATA_W  sample word
in_frame  in  1  frame marker aligned with in_data
in_valid  in  1  in_data/in_frame qualifier
hold  in  1  1 = freeze entire pipeline and settle counter
mute  in  1  1 = force out_data to zero (valid/frame still propagate)
delay_sel  in  SEL_W  requested latency minus one
out_data  out  DATA_W  delayed sample
out_frame  out  1  delayed frame marker
out_valid  out  1  delayed valid, gated by settle state
settled  out  1  1 = state RUN

Behaviour:
- Reset (async, reset_n=0): all stage data/frame/valid = 0; out_data=0, out_frame=0, out_valid=0; state=RUN; settled=1; latched delay = 1 (delay_sel_q=0); settle counter=0.
- Effective delay D = min(delay_sel+1, MAX_DEPTH). delay_sel values >= MAX_DEPTH clamp to MAX_DEPTH.
- Advance cycle = any clock edge with hold=0. On an advance: stage[0] <= {in_data,in_frame,in_valid}; stage[k] <= stage[k-1] for k=1..MAX_DEPTH-1. With hold=1, all stages, outputs and the counter keep their values.
- Outputs are registered from stage[D-1] (D-1 taken from the latched delay), so the output shows stage[D-1] after each edge. A word presented at advance edge n appears on the outputs after advance edge n+D-1. D=1 is identical to the legacy single register.
- out_data = 0 when mute=1 or state=SETTLE; otherwise stage[D-1].data. Mute is combinational into the output register, so it takes effect on the next edge.
- out_frame and out_valid = stage[D-1] values when state=RUN, forced 0 during SETTLE. Mute does not affect them.
- Delay change detection: delay_sel is compared each edge against the latched delay_sel_q, regardless of hold. On mismatch:
  - delay_sel_q <= delay_sel;
  - state <= SETTLE;
  - counter <= new D.
- SETTLE:
  - counter decrements by 1 on each advance cycle; it is frozen while hold=1.
  - When counter reaches 0 (counter==1 on an advance), next state is RUN.
  - A further delay_sel change during SETTLE reloads the counter with the newer D and stays in SETTLE.
  - Stages keep shifting during SETTLE; only the outputs are gated.
- RUN: stays in RUN until a delay_sel change.
- settled is registered: 1 iff state=RUN.
- Simultaneous events:
  - delay change + hold: latch and enter SETTLE; counter loads but does not decrement until hold falls.
  - mute + SETTLE: out_data=0 either way.
- Reset mid-SETTLE returns to RUN with D=1 and clears the pipeline. No partial words survive.
- No backpressure. Input is accepted on every advance cycle; in_valid=0 words propagate as bubbles.

Test Plan:
- Reset then D=1 (delay_sel=0): drive in_data=24'h00_0001..0005, valid=1 on consecutive edges -> out_data shows each word after one edge (legacy behaviour), out_valid=1, settled=1.
- Set delay_sel=3 while streaming an incrementing ramp -> settled=0 and out_valid=0/out_data=0 for exactly 4 advance edges, then out_data equals the input from 4 edges earlier with no skipped or duplicated values.
- delay_sel=4'hF with MAX_DEPTH=16 -> latency 16. With MAX_DEPTH=8, delay_sel=12 clamps -> latency 8 measured from in_frame pulse to out_frame pulse.
- Hold=1 for 3 cycles mid-stream at D=4 -> outputs frozen; after release the sequence resumes with no loss. Repeat with hold asserted during SETTLE -> settle lasts 4 advances plus 3 held cycles.
- mute=1 for 2 cycles in RUN -> out_data=0 for those 2 output cycles while out_valid/out_frame continue to track input.
- Assert reset_n=0 asynchronously mid-SETTLE at D=8 -> all outputs 0 immediately; after release settled=1 and latency is 1.
